// File: rtl/approx_seq_mac_pkg.sv
// Shared FSM encodings and default sizing for the approximate arithmetic blocks.
package approx_seq_mac_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_APPROX_BITS = 4;
  localparam int DEF_ACC_WIDTH   = 24;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/approx_seq_mac_loa_adder.sv
// Lower-part-OR adder: K LSBs are OR-ed, the upper N-K bits add exactly with a carry guessed from bit K-1.
module loa_adder #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] s
);

  generate
    if (K == 0) begin : g_exact
      assign s = x + y;
    end else if (K >= N) begin : g_all_or
      assign s = x | y;
    end else begin : g_loa
      logic cin;
      assign cin        = x[K-1] & y[K-1];
      assign s[K-1:0]   = x[K-1:0] | y[K-1:0];
      assign s[N-1:K]   = x[N-1:K] + y[N-1:K] + (N-K)'(cin);
    end
  endgenerate

endmodule

// File: rtl/approx_seq_mac.sv
// Sequential shift-add multiply with approximate (LOA) additions, folded into a running accumulator.
module approx_seq_mac
  import approx_seq_mac_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int APPROX_BITS = DEF_APPROX_BITS,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [PW-1:0]        prod_q, prod_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [PW-1:0]        partial;
  logic [PW-1:0]        mul_sum;
  logic [ACC_WIDTH-1:0] acc_sum;

  assign partial = {{WIDTH{1'b0}}, a_q} << cnt_q;

  loa_adder #(.N(PW), .K(APPROX_BITS)) u_mul_add (
    .x (prod_q),
    .y (partial),
    .s (mul_sum)
  );

  loa_adder #(.N(ACC_WIDTH), .K(APPROX_BITS)) u_acc_add (
    .x (acc_q),
    .y (ACC_WIDTH'(prod_q)),
    .s (acc_sum)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // clear and a new operand pair may land together; the product then adds onto zero
        if (clear) acc_d = '0;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          prod_d  = '0;
          cnt_d   = '0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        if (b_q[cnt_q]) prod_d = mul_sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_ACC;
      end
      ST_ACC: begin
        acc_d   = acc_sum;
        state_d = ST_DONE;
      end
      default: begin
        if (out_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign acc_out   = acc_q;

endmodule

// File: tb/tb_approx_seq_mac.sv
// Directed bench: exact, approximate and 16-bit-accumulator instances driven one at a time.
module tb_approx_seq_mac;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       in_valid [3];
  logic       clear    [3];
  logic       out_ready[3];
  logic [7:0] a        [3];
  logic [7:0] b        [3];

  logic        in_ready0, in_ready1, in_ready2;
  logic        out_valid0, out_valid1, out_valid2;
  logic        busy0, busy1, busy2;
  logic [23:0] acc0, acc1;
  logic [15:0] acc2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  approx_seq_mac #(.WIDTH(8), .APPROX_BITS(0), .ACC_WIDTH(24)) dut_exact (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready0), .a(a[0]), .b(b[0]),
    .clear(clear[0]), .out_valid(out_valid0), .out_ready(out_ready[0]), .acc_out(acc0), .busy(busy0)
  );

  approx_seq_mac #(.WIDTH(8), .APPROX_BITS(4), .ACC_WIDTH(24)) dut_loa (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready1), .a(a[1]), .b(b[1]),
    .clear(clear[1]), .out_valid(out_valid1), .out_ready(out_ready[1]), .acc_out(acc1), .busy(busy1)
  );

  approx_seq_mac #(.WIDTH(8), .APPROX_BITS(0), .ACC_WIDTH(16)) dut_acc16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready2), .a(a[2]), .b(b[2]),
    .clear(clear[2]), .out_valid(out_valid2), .out_ready(out_ready[2]), .acc_out(acc2), .busy(busy2)
  );

  function automatic logic [31:0] get_acc(input int idx);
    case (idx)
      0:       return {8'd0, acc0};
      1:       return {8'd0, acc1};
      default: return {16'd0, acc2};
    endcase
  endfunction

  function automatic logic get_ov(input int idx);
    case (idx)
      0:       return out_valid0;
      1:       return out_valid1;
      default: return out_valid2;
    endcase
  endfunction

  function automatic logic get_ir(input int idx);
    case (idx)
      0:       return in_ready0;
      1:       return in_ready1;
      default: return in_ready2;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Presents one operand pair, measures accept-to-out_valid latency (accept cycle counts as 1)
  task automatic run_txn(input int idx, input logic [7:0] av, input logic [7:0] bv, input logic clr,
                         input logic [31:0] exp_acc, input string tag, input bit release_done);
    int cyc;
    @(negedge clk);
    check_val({tag, "_in_ready"}, {31'd0, get_ir(idx)}, 32'd1);
    in_valid[idx] = 1'b1;
    clear[idx]    = clr;
    a[idx]        = av;
    b[idx]        = bv;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    in_valid[idx] = 1'b0;
    clear[idx]    = 1'b0;
    a[idx]        = ~av;
    b[idx]        = ~bv;
    while (!get_ov(idx) && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check_val({tag, "_latency"}, cyc, 32'd10);
    check_val({tag, "_acc"}, get_acc(idx), exp_acc);
    if (release_done) begin
      @(posedge clk);
      @(negedge clk);
      check_val({tag, "_ov_drop"}, {31'd0, get_ov(idx)}, 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      clear[i]     = 1'b0;
      out_ready[i] = 1'b1;
      a[i]         = 8'd0;
      b[i]         = 8'd0;
    end

    #12;
    check_val("rst_in_ready", {31'd0, in_ready0}, 32'd0);
    check_val("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    check_val("rst_acc", {8'd0, acc0}, 32'd0);
    check_val("rst_busy", {31'd0, busy0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // exact multiply, largest operands
    run_txn(0, 8'd255, 8'd255, 1'b1, 32'd65025, "exact1", 1'b1);
    run_txn(0, 8'd255, 8'd255, 1'b0, 32'd130050, "exact2", 1'b1);

    // LOA with 4 approximate bits: 7*3 -> 15, then LOA(15,15)=31 (carry guess from bit 3)
    run_txn(1, 8'd7, 8'd3, 1'b1, 32'd15, "loa1", 1'b1);
    run_txn(1, 8'd3, 8'd5, 1'b0, 32'd31, "loa2", 1'b1);
    run_txn(1, 8'd9, 8'd0, 1'b0, 32'd31, "loa_b0", 1'b1);

    // 16-bit accumulator wraps
    run_txn(2, 8'd255, 8'd255, 1'b1, 32'd65025, "wrap1", 1'b1);
    run_txn(2, 8'd255, 8'd255, 1'b0, 32'd64514, "wrap2", 1'b1);

    // clear together with a new pair: 100 is discarded, result is 2*3
    run_txn(0, 8'd10, 8'd10, 1'b1, 32'd100, "pre_clear", 1'b1);
    run_txn(0, 8'd2, 8'd3, 1'b1, 32'd6, "clear_same", 1'b1);

    // backpressure in DONE with in_valid/clear asserted
    out_ready[0] = 1'b0;
    run_txn(0, 8'd1, 8'd1, 1'b0, 32'd7, "bp", 1'b0);
    in_valid[0] = 1'b1;
    clear[0]    = 1'b1;
    a[0]        = 8'd50;
    b[0]        = 8'd50;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("bp_ov", {31'd0, out_valid0}, 32'd1);
      check_val("bp_acc", {8'd0, acc0}, 32'd7);
      check_val("bp_in_ready", {31'd0, in_ready0}, 32'd0);
    end
    in_valid[0]  = 1'b0;
    clear[0]     = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("bp_ov_drop", {31'd0, out_valid0}, 32'd0);
    check_val("bp_acc_after", {8'd0, acc0}, 32'd7);

    // reset during the fourth MUL cycle
    @(negedge clk);
    in_valid[0] = 1'b1;
    a[0]        = 8'd5;
    b[0]        = 8'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    check_val("mid_busy", {31'd0, busy0}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_acc", {8'd0, acc0}, 32'd0);
    check_val("mid_rst_busy", {31'd0, busy0}, 32'd0);
    check_val("mid_rst_ov", {31'd0, out_valid0}, 32'd0);
    check_val("mid_rst_in_ready", {31'd0, in_ready0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_txn(0, 8'd4, 8'd4, 1'b0, 32'd16, "post_rst", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
